mc6821_pia: RTL and testbench

Synthesizable Motorola MC6821 Peripheral Interface Adapter for the arcade sound and data CPU buses. It provides two 8-bit ports (A, B) with data-direction registers, two control registers, and CA1/CA2 and CB1/CB2 control lines. It raises interrupts on control-line edges and supports CA2/CB2 handshake and pulse outputs. It runs on the system clock; the bus side is qualified by a one-clock chip-select strobe generated by the CPU clock enable.

---
 rtl/mc6821_pia.sv | 175 +++++++++++++++++
 tb/tb_mc6821_pia.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc6821_pia.sv
// MC6821 peripheral interface adapter: two 8-bit ports with direction registers,
// control registers, C1/C2 edge interrupts and C2 handshake/pulse/manual outputs.
module mc6821_pia (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cs,
   input  logic                 rw,
   input  logic [1:0]           addr,
   input  logic [7:0]           data_in,
   output logic [7:0]           data_out,
   output logic                 irqa,
   output logic                 irqb,
   input  logic [7:0]           pa_i,
   output logic [7:0]           pa_o,
   output logic [7:0]           pa_oe,
   input  logic                 ca1,
   input  logic                 ca2_i,
   output logic                 ca2_o,
   output logic                 ca2_oe,
   input  logic [7:0]           pb_i,
   output logic [7:0]           pb_o,
   output logic [7:0]           pb_oe,
   input  logic                 cb1,
   input  logic                 cb2_i,
   output logic                 cb2_o,
   output logic                 cb2_oe
);

   localparam int unsigned DW  = 8;
   localparam int unsigned CRW = 6;

   logic [DW-1:0]  ora, ddra, orb, ddrb;
   logic [CRW-1:0] cra, crb;
   logic           irqa1, irqa2, irqb1, irqb2;
   logic           ca2_out, cb2_out;
   logic           ca1_q, ca2_q, cb1_q, cb2_q;

   logic           wr, rd;
   logic           cra_wr, crb_wr, ora_wr, ddra_wr, orb_wr, ddrb_wr;
   logic           pa_rd, pb_rd, pb_wr;
   logic           ca1_act, ca2_act, cb1_act, cb2_act;
   logic [CRW-1:0] cra_nx, crb_nx;
   logic           ca2_nx, cb2_nx;
   logic           irqa1_nx, irqa2_nx, irqb1_nx, irqb2_nx;
   logic [DW-1:0]  pa_val, pb_val;

   // Bus decode
   always_comb begin
      wr      = cs & ~rw;
      rd      = cs & rw;
      cra_wr  = wr & (addr == 2'd1);
      crb_wr  = wr & (addr == 2'd3);
      ora_wr  = wr & (addr == 2'd0) & cra[2];
      ddra_wr = wr & (addr == 2'd0) & ~cra[2];
      orb_wr  = wr & (addr == 2'd2) & crb[2];
      ddrb_wr = wr & (addr == 2'd2) & ~crb[2];
      pa_rd   = rd & (addr == 2'd0) & cra[2];
      pb_rd   = rd & (addr == 2'd2) & crb[2];
      pb_wr   = orb_wr;
   end

   // Active-edge detection against the previous sample
   always_comb begin
      ca1_act = cra[1] ? (ca1 & ~ca1_q) : (~ca1 & ca1_q);
      cb1_act = crb[1] ? (cb1 & ~cb1_q) : (~cb1 & cb1_q);
      ca2_act = ~cra[5] & (cra[4] ? (ca2_i & ~ca2_q) : (~ca2_i & ca2_q));
      cb2_act = ~crb[5] & (crb[4] ? (cb2_i & ~cb2_q) : (~cb2_i & cb2_q));
   end

   // Next-state for flags and C2 outputs; a setting edge beats a clearing read
   always_comb begin
      cra_nx   = cra;
      crb_nx   = crb;
      irqa1_nx = irqa1;
      irqa2_nx = irqa2;
      irqb1_nx = irqb1;
      irqb2_nx = irqb2;
      ca2_nx   = ca2_out;
      cb2_nx   = cb2_out;

      if (cra_wr) cra_nx = data_in[CRW-1:0];
      if (crb_wr) crb_nx = data_in[CRW-1:0];

      if (pa_rd) begin
         irqa1_nx = 1'b0;
         irqa2_nx = 1'b0;
      end
      if (ca1_act) irqa1_nx = 1'b1;
      if (ca2_act) irqa2_nx = 1'b1;

      if (pb_rd) begin
         irqb1_nx = 1'b0;
         irqb2_nx = 1'b0;
      end
      if (cb1_act) irqb1_nx = 1'b1;
      if (cb2_act) irqb2_nx = 1'b1;

      if (!cra_nx[5])                 ca2_nx = 1'b1;
      else if (cra_nx[4])             ca2_nx = cra_nx[3];
      else if (pa_rd)                 ca2_nx = 1'b0;
      else if (!cra_nx[3] && ca1_act) ca2_nx = 1'b1;
      else if (cra_nx[3] && cs)       ca2_nx = 1'b1;

      if (!crb_nx[5])                 cb2_nx = 1'b1;
      else if (crb_nx[4])             cb2_nx = crb_nx[3];
      else if (pb_wr)                 cb2_nx = 1'b0;
      else if (!crb_nx[3] && cb1_act) cb2_nx = 1'b1;
      else if (crb_nx[3] && cs)       cb2_nx = 1'b1;
   end

   // Register state; edge history reloads from the pins so reset creates no edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ora     <= '0;
         ddra    <= '0;
         orb     <= '0;
         ddrb    <= '0;
         cra     <= '0;
         crb     <= '0;
         irqa1   <= 1'b0;
         irqa2   <= 1'b0;
         irqb1   <= 1'b0;
         irqb2   <= 1'b0;
         ca2_out <= 1'b1;
         cb2_out <= 1'b1;
         ca1_q   <= ca1;
         ca2_q   <= ca2_i;
         cb1_q   <= cb1;
         cb2_q   <= cb2_i;
      end else begin
         if (ora_wr)  ora  <= data_in;
         if (ddra_wr) ddra <= data_in;
         if (orb_wr)  orb  <= data_in;
         if (ddrb_wr) ddrb <= data_in;
         cra     <= cra_nx;
         crb     <= crb_nx;
         irqa1   <= irqa1_nx;
         irqa2   <= irqa2_nx;
         irqb1   <= irqb1_nx;
         irqb2   <= irqb2_nx;
         ca2_out <= ca2_nx;
         cb2_out <= cb2_nx;
         ca1_q   <= ca1;
         ca2_q   <= ca2_i;
         cb1_q   <= cb1;
         cb2_q   <= cb2_i;
      end
   end

   // Read mux, always driven
   always_comb begin
      pa_val = (ora & ddra) | (pa_i & ~ddra);
      pb_val = (orb & ddrb) | (pb_i & ~ddrb);
      case (addr)
         2'd0:    data_out = cra[2] ? pa_val : ddra;
         2'd1:    data_out = {irqa1, irqa2, cra};
         2'd2:    data_out = crb[2] ? pb_val : ddrb;
         default: data_out = {irqb1, irqb2, crb};
      endcase
   end

   always_comb begin
      irqa   = (irqa1 & cra[0]) | (irqa2 & cra[3] & ~cra[5]);
      irqb   = (irqb1 & crb[0]) | (irqb2 & crb[3] & ~crb[5]);
      pa_o   = ora;
      pa_oe  = ddra;
      pb_o   = orb;
      pb_oe  = ddrb;
      ca2_o  = ca2_out;
      ca2_oe = cra[5];
      cb2_o  = cb2_out;
      cb2_oe = crb[5];
   end

endmodule

// File: tb/tb_mc6821_pia.sv
// Bench for mc6821_pia: directed vector table, corner sequences, then random
// traffic checked against a per-port behavioural model.
module tb_mc6821_pia;

   logic       clk = 1'b0;
   logic       rst;
   logic       cs, rw;
   logic [1:0] addr;
   logic [7:0] data_in, data_out;
   logic       irqa, irqb;
   logic [7:0] pa_i, pa_o, pa_oe, pb_i, pb_o, pb_oe;
   logic       ca1, ca2_i, ca2_o, ca2_oe, cb1, cb2_i, cb2_o, cb2_oe;

   int n_checks = 0;
   int n_errors = 0;

   mc6821_pia dut (
      .clk(clk), .rst(rst), .cs(cs), .rw(rw), .addr(addr),
      .data_in(data_in), .data_out(data_out), .irqa(irqa), .irqb(irqb),
      .pa_i(pa_i), .pa_o(pa_o), .pa_oe(pa_oe), .ca1(ca1), .ca2_i(ca2_i),
      .ca2_o(ca2_o), .ca2_oe(ca2_oe), .pb_i(pb_i), .pb_o(pb_o), .pb_oe(pb_oe),
      .cb1(cb1), .cb2_i(cb2_i), .cb2_o(cb2_o), .cb2_oe(cb2_oe)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   // Model: one record per port, indexed by addr[1]
   typedef struct packed {
      logic [7:0] orr;
      logic [7:0] ddr;
      logic [5:0] cr;
      logic       f1, f2, c2, c1p, c2p;
   } port_t;
   port_t mp [2];

   typedef struct {
      logic       cs, rw;
      logic [1:0] addr;
      logic [7:0] din;
      logic       ca1, cb1;
      logic [7:0] dout, pa_o, pa_oe, pb_o, pb_oe;
      logic       irqa, irqb, ca2, ca2oe, cb2, cb2oe;
   } vec_t;
   vec_t tq [$];

   function automatic vec_t mk(int c, int r, int a, int d, int a1, int b1,
                               int dout, int pao, int paoe, int pbo, int pboe,
                               int ia, int ib, int c2a, int c2aoe, int c2b, int c2boe);
      vec_t v;
      v.cs = 1'(c);       v.rw = 1'(r);       v.addr = 2'(a);   v.din = 8'(d);
      v.ca1 = 1'(a1);     v.cb1 = 1'(b1);     v.dout = 8'(dout);
      v.pa_o = 8'(pao);   v.pa_oe = 8'(paoe); v.pb_o = 8'(pbo); v.pb_oe = 8'(pboe);
      v.irqa = 1'(ia);    v.irqb = 1'(ib);
      v.ca2 = 1'(c2a);    v.ca2oe = 1'(c2aoe); v.cb2 = 1'(c2b); v.cb2oe = 1'(c2boe);
      return v;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      for (int p = 0; p < 2; p++) begin
         mp[p]     = '0;
         mp[p].c2  = 1'b1;
         mp[p].c1p = (p == 0) ? ca1 : cb1;
         mp[p].c2p = (p == 0) ? ca2_i : cb2_i;
      end
   endtask

   function automatic logic [7:0] m_read(input logic [1:0] a);
      port_t      q;
      logic [7:0] pin;
      q   = mp[a[1]];
      pin = a[1] ? pb_i : pa_i;
      if (a[0]) return {q.f1, q.f2, q.cr};
      if (q.cr[2]) return (q.orr & q.ddr) | (pin & ~q.ddr);
      return q.ddr;
   endfunction

   function automatic logic m_irq(input int p);
      return (mp[p].f1 & mp[p].cr[0]) | (mp[p].f2 & mp[p].cr[3] & ~mp[p].cr[5]);
   endfunction

   // One rising edge of the model, from the pin/bus values currently applied
   task automatic m_clock();
      port_t o, n;
      logic  c1, c2, act1, act2, mine, dacc, trig;
      for (int p = 0; p < 2; p++) begin
         o = mp[p];
         n = o;
         c1   = (p == 0) ? ca1 : cb1;
         c2   = (p == 0) ? ca2_i : cb2_i;
         act1 = o.cr[1] ? (c1 && !o.c1p) : (!c1 && o.c1p);
         act2 = !o.cr[5] && (o.cr[4] ? (c2 && !o.c2p) : (!c2 && o.c2p));
         mine = cs && (int'(addr[1]) == p);
         dacc = mine && !addr[0] && o.cr[2];
         if (mine && !rw) begin
            if (addr[0])     n.cr  = data_in[5:0];
            else if (o.cr[2]) n.orr = data_in;
            else             n.ddr = data_in;
         end
         if (dacc && rw) begin
            n.f1 = 1'b0;
            n.f2 = 1'b0;
         end
         if (act1) n.f1 = 1'b1;
         if (act2) n.f2 = 1'b1;
         trig = dacc && ((p == 0) ? rw : !rw);
         if (!n.cr[5])                n.c2 = 1'b1;
         else if (n.cr[4])            n.c2 = n.cr[3];
         else if (trig)               n.c2 = 1'b0;
         else if (!n.cr[3] && act1)   n.c2 = 1'b1;
         else if (n.cr[3] && cs)      n.c2 = 1'b1;
         n.c1p = c1;
         n.c2p = c2;
         mp[p] = n;
      end
   endtask

   task automatic step(input logic c, input logic r, input logic [1:0] a,
                       input logic [7:0] d, input bit pre);
      cs = c; rw = r; addr = a; data_in = d;
      #1;
      if (pre) chk("dout_pre", data_out, m_read(a));
      @(posedge clk);
      m_clock();
      #1;
   endtask

   task automatic cmp_all();
      chk("pa_o",   pa_o,   mp[0].orr);
      chk("pa_oe",  pa_oe,  mp[0].ddr);
      chk("pb_o",   pb_o,   mp[1].orr);
      chk("pb_oe",  pb_oe,  mp[1].ddr);
      chk("irqa",   8'(irqa),   8'(m_irq(0)));
      chk("irqb",   8'(irqb),   8'(m_irq(1)));
      chk("ca2_o",  8'(ca2_o),  8'(mp[0].c2));
      chk("ca2_oe", 8'(ca2_oe), 8'(mp[0].cr[5]));
      chk("cb2_o",  8'(cb2_o),  8'(mp[1].c2));
      chk("cb2_oe", 8'(cb2_oe), 8'(mp[1].cr[5]));
      chk("dout",   data_out, m_read(addr));
   endtask

   initial begin
      vec_t v;
      rst = 1'b0; cs = 1'b0; rw = 1'b1; addr = 2'd0; data_in = 8'h00;
      pa_i = 8'h00; pb_i = 8'h3C; ca1 = 1'b0; cb1 = 1'b1; ca2_i = 1'b1; cb2_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      m_reset();
      #1;
      chk("rst_pa_o", pa_o, 8'h00);
      chk("rst_pa_oe", pa_oe, 8'h00);
      chk("rst_ca2_o", 8'(ca2_o), 8'h01);
      chk("rst_cb2_oe", 8'(cb2_oe), 8'h00);
      chk("rst_irqa", 8'(irqa), 8'h00);

      // cs rw a din ca1 cb1 | dout pa_o pa_oe pb_o pb_oe irqa irqb ca2 ca2oe cb2 cb2oe
      tq.push_back(mk(1,0,1,'h00, 0,1, 'h00, 'h00,'h00,'h00,'h00, 0,0, 1,0, 1,0));
      tq.push_back(mk(1,0,0,'hFF, 0,1, 'hFF, 'h00,'hFF,'h00,'h00, 0,0, 1,0, 1,0));
      tq.push_back(mk(1,0,1,'h04, 0,1, 'h04, 'h00,'hFF,'h00,'h00, 0,0, 1,0, 1,0));
      tq.push_back(mk(1,0,0,'h5A, 0,1, 'h5A, 'h5A,'hFF,'h00,'h00, 0,0, 1,0, 1,0));
      tq.push_back(mk(1,1,0,'h00, 0,1, 'h5A, 'h5A,'hFF,'h00,'h00, 0,0, 1,0, 1,0));
      tq.push_back(mk(1,0,3,'h00, 0,1, 'h00, 'h5A,'hFF,'h00,'h00, 0,0, 1,0, 1,0));
      tq.push_back(mk(1,0,2,'h0F, 0,1, 'h0F, 'h5A,'hFF,'h00,'h0F, 0,0, 1,0, 1,0));
      tq.push_back(mk(1,0,3,'h04, 0,1, 'h04, 'h5A,'hFF,'h00,'h0F, 0,0, 1,0, 1,0));
      tq.push_back(mk(1,0,2,'hA5, 0,1, 'h35, 'h5A,'hFF,'hA5,'h0F, 0,0, 1,0, 1,0));
      tq.push_back(mk(1,1,2,'h00, 0,1, 'h35, 'h5A,'hFF,'hA5,'h0F, 0,0, 1,0, 1,0));
      tq.push_back(mk(1,0,1,'h07, 0,1, 'h07, 'h5A,'hFF,'hA5,'h0F, 0,0, 1,0, 1,0));
      tq.push_back(mk(0,1,1,'h00, 1,1, 'h87, 'h5A,'hFF,'hA5,'h0F, 1,0, 1,0, 1,0));
      tq.push_back(mk(1,1,1,'h00, 1,1, 'h87, 'h5A,'hFF,'hA5,'h0F, 1,0, 1,0, 1,0));
      tq.push_back(mk(1,1,0,'h00, 1,1, 'h5A, 'h5A,'hFF,'hA5,'h0F, 0,0, 1,0, 1,0));
      tq.push_back(mk(0,1,1,'h00, 0,1, 'h07, 'h5A,'hFF,'hA5,'h0F, 0,0, 1,0, 1,0));
      tq.push_back(mk(1,0,1,'h3C, 0,1, 'h3C, 'h5A,'hFF,'hA5,'h0F, 0,0, 1,1, 1,0));
      tq.push_back(mk(1,0,1,'h34, 0,1, 'h34, 'h5A,'hFF,'hA5,'h0F, 0,0, 0,1, 1,0));
      tq.push_back(mk(1,0,1,'h24, 0,1, 'h24, 'h5A,'hFF,'hA5,'h0F, 0,0, 0,1, 1,0));
      tq.push_back(mk(0,1,1,'h00, 1,1, 'h24, 'h5A,'hFF,'hA5,'h0F, 0,0, 0,1, 1,0));
      tq.push_back(mk(0,1,1,'h00, 0,1, 'hA4, 'h5A,'hFF,'hA5,'h0F, 0,0, 1,1, 1,0));
      tq.push_back(mk(1,1,0,'h00, 0,1, 'h5A, 'h5A,'hFF,'hA5,'h0F, 0,0, 0,1, 1,0));
      tq.push_back(mk(0,1,1,'h00, 1,1, 'h24, 'h5A,'hFF,'hA5,'h0F, 0,0, 0,1, 1,0));
      tq.push_back(mk(0,1,1,'h00, 0,1, 'hA4, 'h5A,'hFF,'hA5,'h0F, 0,0, 1,1, 1,0));
      tq.push_back(mk(1,0,1,'h2C, 0,1, 'hAC, 'h5A,'hFF,'hA5,'h0F, 0,0, 1,1, 1,0));
      tq.push_back(mk(1,1,0,'h00, 0,1, 'h5A, 'h5A,'hFF,'hA5,'h0F, 0,0, 0,1, 1,0));
      tq.push_back(mk(0,1,1,'h00, 0,1, 'h2C, 'h5A,'hFF,'hA5,'h0F, 0,0, 0,1, 1,0));
      tq.push_back(mk(0,1,1,'h00, 0,1, 'h2C, 'h5A,'hFF,'hA5,'h0F, 0,0, 0,1, 1,0));
      tq.push_back(mk(1,1,3,'h00, 0,1, 'h04, 'h5A,'hFF,'hA5,'h0F, 0,0, 1,1, 1,0));
      tq.push_back(mk(1,0,3,'h24, 0,1, 'h24, 'h5A,'hFF,'hA5,'h0F, 0,0, 1,1, 1,1));
      tq.push_back(mk(1,0,2,'h77, 0,1, 'h37, 'h5A,'hFF,'h77,'h0F, 0,0, 1,1, 0,1));
      tq.push_back(mk(0,1,3,'h00, 0,0, 'hA4, 'h5A,'hFF,'h77,'h0F, 0,0, 1,1, 1,1));
      tq.push_back(mk(1,0,3,'h25, 0,0, 'hA5, 'h5A,'hFF,'h77,'h0F, 0,1, 1,1, 1,1));
      tq.push_back(mk(1,1,2,'h00, 0,0, 'h37, 'h5A,'hFF,'h77,'h0F, 0,0, 1,1, 1,1));

      foreach (tq[i]) begin
         v = tq[i];
         ca1 = v.ca1;
         cb1 = v.cb1;
         step(v.cs, v.rw, v.addr, v.din, 1'b0);
         chk($sformatf("v%0d_dout", i),  data_out, v.dout);
         chk($sformatf("v%0d_pa_o", i),  pa_o,  v.pa_o);
         chk($sformatf("v%0d_pa_oe", i), pa_oe, v.pa_oe);
         chk($sformatf("v%0d_pb_o", i),  pb_o,  v.pb_o);
         chk($sformatf("v%0d_pb_oe", i), pb_oe, v.pb_oe);
         chk($sformatf("v%0d_irqa", i),  8'(irqa),   8'(v.irqa));
         chk($sformatf("v%0d_irqb", i),  8'(irqb),   8'(v.irqb));
         chk($sformatf("v%0d_ca2", i),   8'(ca2_o),  8'(v.ca2));
         chk($sformatf("v%0d_ca2oe", i), 8'(ca2_oe), 8'(v.ca2oe));
         chk($sformatf("v%0d_cb2", i),   8'(cb2_o),  8'(v.cb2));
         chk($sformatf("v%0d_cb2oe", i), 8'(cb2_oe), 8'(v.cb2oe));
      end

      // Rising ca1 edge coinciding with the clearing port-A read: flag stays set
      ca1 = 1'b0;
      step(1'b1, 1'b0, 2'd1, 8'h07, 1'b0);
      ca1 = 1'b1;
      step(1'b1, 1'b1, 2'd0, 8'h00, 1'b0);
      chk("setwins_irqa", 8'(irqa), 8'h01);
      step(1'b0, 1'b1, 2'd1, 8'h00, 1'b0);
      chk("setwins_cra", data_out, 8'h87);

      // Reset asserted in the middle of a write cycle
      cs = 1'b1; rw = 1'b0; addr = 2'd1; data_in = 8'h3F;
      #2;
      rst = 1'b0;
      #1;
      chk("midrst_pa_o", pa_o, 8'h00);
      chk("midrst_pa_oe", pa_oe, 8'h00);
      chk("midrst_pb_o", pb_o, 8'h00);
      chk("midrst_ca2_oe", 8'(ca2_oe), 8'h00);
      chk("midrst_cb2_o", 8'(cb2_o), 8'h01);
      chk("midrst_irqa", 8'(irqa), 8'h00);
      chk("midrst_dout", data_out, 8'h00);
      cs = 1'b0;
      @(posedge clk);
      #1;
      ca1 = 1'b0;
      cb1 = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      m_reset();
      step(1'b0, 1'b1, 2'd1, 8'h00, 1'b0);
      chk("post_rst_no_edge", data_out, 8'h00);
      cmp_all();

      // Random traffic against the model
      for (int k = 0; k < 3000; k++) begin
         pa_i = 8'($urandom);
         pb_i = 8'($urandom);
         if ($urandom_range(3) == 0) ca1   = ~ca1;
         if ($urandom_range(3) == 0) cb1   = ~cb1;
         if ($urandom_range(3) == 0) ca2_i = ~ca2_i;
         if ($urandom_range(3) == 0) cb2_i = ~cb2_i;
         step(1'($urandom_range(1)), 1'($urandom_range(1)), 2'($urandom_range(3)),
              8'($urandom), 1'b1);
         cmp_all();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
